dendrite_arbiter: RTL and testbench

DENDRITE_ARBITER -- requirements
Module: dendrite_arbiter

---
 rtl/dendrite_arbiter.sv | 131 +++++++++++++
 tb/tb_dendrite_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dendrite_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : dendrite_arbiter                                            |
// | Description : Picks one of NUM_SYN synapse ports or the incoming port and |
// |               places it in a single-entry output register. The incoming   |
// |               port always wins. Define DENDRITE_ARB_RR_EN to use          |
// |               round-robin among synapses; otherwise lowest index wins.    |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module dendrite_arbiter #(
  parameter int NUM_SYN  = 4,
  parameter int ADDR_W   = 8,
  parameter int CHARGE_W = 8,
  localparam int SRC_W   = $clog2(NUM_SYN + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_SYN*ADDR_W-1:0]    syn_addr,
  input  logic [NUM_SYN*CHARGE_W-1:0]  syn_charge,
  input  logic [NUM_SYN-1:0]           syn_vld,
  output logic [NUM_SYN-1:0]           syn_rdy,
  input  logic [ADDR_W-1:0]            incoming_addr,
  input  logic [CHARGE_W-1:0]          incoming_charge,
  input  logic                         incoming_vld,
  output logic                         incoming_rdy,
  output logic [ADDR_W-1:0]            dend_addr,
  output logic [CHARGE_W:0]            dend_charge,
  output logic [SRC_W-1:0]             dend_src,
  output logic                         dend_vld,
  input  logic                         dend_rdy
);

  localparam int IDX_W = $clog2(NUM_SYN);

  logic [ADDR_W-1:0]   addr_arr [NUM_SYN];
  logic [CHARGE_W-1:0] chg_arr  [NUM_SYN];
  logic                slot_free;
  logic                can_grant;
  logic                inc_gnt;
  logic                syn_gnt;
  logic                syn_found;
  logic [IDX_W-1:0]    syn_sel;
  logic [ADDR_W-1:0]   sel_addr;
  logic [CHARGE_W-1:0] sel_chg;

  assign slot_free = !dend_vld || dend_rdy;
  // Reset gating keeps every ready low while reset is held.
  assign can_grant = enable && slot_free && !reset;
  assign inc_gnt   = can_grant && incoming_vld;
  assign syn_gnt   = can_grant && !incoming_vld && syn_found;

  assign incoming_rdy = inc_gnt;

  generate
    for (genvar i = 0; i < NUM_SYN; i++) begin : g_port
      assign addr_arr[i] = syn_addr[i*ADDR_W +: ADDR_W];
      assign chg_arr[i]  = syn_charge[i*CHARGE_W +: CHARGE_W];
      assign syn_rdy[i]  = syn_gnt && (syn_sel == IDX_W'(i));
    end
  endgenerate

`ifdef DENDRITE_ARB_RR_EN
  logic [IDX_W-1:0] last_syn;
  logic [IDX_W-1:0] cand;

  // Search starts one past the last granted synapse and wraps.
  always_comb begin
    syn_found = 1'b0;
    syn_sel   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_SYN; k++) begin
      cand = IDX_W'((int'(last_syn) + k) % NUM_SYN);
      if (!syn_found && syn_vld[cand]) begin
        syn_found = 1'b1;
        syn_sel   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_syn <= IDX_W'(NUM_SYN - 1);
    end else if (syn_gnt) begin
      last_syn <= syn_sel;
    end
  end
`else
  always_comb begin
    syn_found = |syn_vld;
    syn_sel   = '0;
    for (int i = NUM_SYN - 1; i >= 0; i--) begin
      if (syn_vld[IDX_W'(i)]) begin
        syn_sel = IDX_W'(i);
      end
    end
  end
`endif

  assign sel_addr = addr_arr[syn_sel];
  assign sel_chg  = chg_arr[syn_sel];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dend_vld    <= 1'b0;
      dend_addr   <= '0;
      dend_charge <= '0;
      dend_src    <= '0;
    end else if (inc_gnt) begin
      dend_vld    <= 1'b1;
      dend_addr   <= incoming_addr;
      dend_charge <= {1'b0, incoming_charge};
      dend_src    <= SRC_W'(NUM_SYN);
    end else if (syn_gnt) begin
      dend_vld    <= 1'b1;
      dend_addr   <= sel_addr;
      dend_charge <= {sel_chg[CHARGE_W-1], sel_chg};
      dend_src    <= SRC_W'(syn_sel);
    end else if (dend_rdy) begin
      dend_vld    <= 1'b0;
    end
  end

  a_one_grant : assert property (@(posedge clk) disable iff (reset)
    $onehot0({incoming_rdy, syn_rdy}));

  a_hold_stable : assert property (@(posedge clk) disable iff (reset)
    (dend_vld && !dend_rdy) |=> $stable({dend_addr, dend_charge, dend_src}) && dend_vld);

endmodule
`default_nettype wire

// File: tb/tb_dendrite_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : tb_dendrite_arbiter                                         |
// | Description : Scoreboard bench for dendrite_arbiter (4 synapse ports).    |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module tb_dendrite_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] syn_addr;
  logic [31:0] syn_charge;
  logic [3:0]  syn_vld;
  logic [3:0]  syn_rdy;
  logic [7:0]  incoming_addr;
  logic [7:0]  incoming_charge;
  logic        incoming_vld;
  logic        incoming_rdy;
  logic [7:0]  dend_addr;
  logic [8:0]  dend_charge;
  logic [2:0]  dend_src;
  logic        dend_vld;
  logic        dend_rdy;

  typedef struct packed {
    logic [7:0] addr;
    logic [8:0] chg;
    logic [2:0] src;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Hand-computed output per source: synapse charges sign-extended, incoming zero-extended.
  logic [7:0] exp_addr [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hA5};
  logic [8:0] exp_chg  [5] = '{9'h001, 9'h180, 9'h1F0, 9'h07F, 9'h0F0};

`ifdef DENDRITE_ARB_RR_EN
  localparam logic [3:0] G3 = 4'b1000, G4 = 4'b0001, G5 = 4'b0010, G6 = 4'b0100;
  localparam logic [3:0] G7 = 4'b1000, G10 = 4'b0001, G14 = 4'b0010;
`else
  localparam logic [3:0] G3 = 4'b0001, G4 = 4'b0001, G5 = 4'b0001, G6 = 4'b0001;
  localparam logic [3:0] G7 = 4'b0001, G10 = 4'b0001, G14 = 4'b0001;
`endif

  dendrite_arbiter #(.NUM_SYN(4), .ADDR_W(8), .CHARGE_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .syn_addr        (syn_addr),
    .syn_charge      (syn_charge),
    .syn_vld         (syn_vld),
    .syn_rdy         (syn_rdy),
    .incoming_addr   (incoming_addr),
    .incoming_charge (incoming_charge),
    .incoming_vld    (incoming_vld),
    .incoming_rdy    (incoming_rdy),
    .dend_addr       (dend_addr),
    .dend_charge     (dend_charge),
    .dend_src        (dend_src),
    .dend_vld        (dend_vld),
    .dend_rdy        (dend_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total = n_total + 1;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass = n_pass + 1;
    end
  endtask

  // One cycle: drive inputs, check readies and dend_vld at negedge, push the expected grant.
  task automatic step(input int id, input logic [3:0] sv, input logic iv, input logic en,
                      input logic dr, input logic [3:0] e_srdy, input logic e_irdy,
                      input logic e_dvld);
    int   src;
    exp_t e;
    syn_vld      = sv;
    incoming_vld = iv;
    enable       = en;
    dend_rdy     = dr;
    @(negedge clk);
    check($sformatf("s%0d_syn_rdy", id), 32'(syn_rdy), 32'(e_srdy));
    check($sformatf("s%0d_inc_rdy", id), 32'(incoming_rdy), 32'(e_irdy));
    check($sformatf("s%0d_dend_vld", id), 32'(dend_vld), 32'(e_dvld));
    if (e_irdy || (e_srdy != 4'b0000)) begin
      src = 4;
      if (!e_irdy) begin
        for (int i = 0; i < 4; i++) begin
          if (e_srdy[i]) src = i;
        end
      end
      e.addr = exp_addr[src];
      e.chg  = exp_chg[src];
      e.src  = 3'(src);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: any presented output must match the oldest outstanding grant.
  always @(negedge clk) begin
    if (!reset && dend_vld) begin
      if (q.size() == 0) begin
        n_total = n_total + 1;
        $display("FAIL unexpected_output: got src %0d expected no output", dend_src);
      end else begin
        check("out_addr", 32'(dend_addr), 32'(q[0].addr));
        check("out_charge", 32'(dend_charge), 32'(q[0].chg));
        check("out_src", 32'(dend_src), 32'(q[0].src));
        if (dend_rdy) void'(q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    enable          = 1'b1;
    syn_addr        = {8'h13, 8'h12, 8'h11, 8'h10};
    syn_charge      = {8'h7F, 8'hF0, 8'h80, 8'h01};
    syn_vld         = 4'b1111;
    incoming_addr   = 8'hA5;
    incoming_charge = 8'hF0;
    incoming_vld    = 1'b1;
    dend_rdy        = 1'b0;

    @(negedge clk);
    check("rst_syn_rdy", 32'(syn_rdy), 32'h0);
    check("rst_inc_rdy", 32'(incoming_rdy), 32'h0);
    check("rst_dend_vld", 32'(dend_vld), 32'h0);
    check("rst_dend_addr", 32'(dend_addr), 32'h0);
    check("rst_dend_charge", 32'(dend_charge), 32'h0);
    check("rst_dend_src", 32'(dend_src), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single synapse, then incoming priority over all synapses.
    step(1,  4'b0100, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b0, 1'b0);
    step(2,  4'b1111, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1);
    // Synapse arbitration with all valids held; incoming grant left the pointer alone.
    step(3,  4'b1111, 1'b0, 1'b1, 1'b1, G3,      1'b0, 1'b1);
    step(4,  4'b1111, 1'b0, 1'b1, 1'b1, G4,      1'b0, 1'b1);
    step(5,  4'b1111, 1'b0, 1'b1, 1'b1, G5,      1'b0, 1'b1);
    step(6,  4'b1111, 1'b0, 1'b1, 1'b1, G6,      1'b0, 1'b1);
    // Backpressure: stall two cycles, then back-to-back grant on release.
    step(7,  4'b1111, 1'b0, 1'b1, 1'b1, G7,      1'b0, 1'b1);
    step(8,  4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
    step(9,  4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
    step(10, 4'b1111, 1'b0, 1'b1, 1'b1, G10,     1'b0, 1'b1);
    // Enable low: held output drains, no grants until enable returns.
    step(11, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    step(12, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);
    step(13, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0);
    step(14, 4'b1111, 1'b0, 1'b1, 1'b1, G14,     1'b0, 1'b0);
    // Reset in the middle of a stall discards the held output asynchronously.
    step(15, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_vld", 32'(dend_vld), 32'h0);
    check("async_rst_addr", 32'(dend_addr), 32'h0);
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(16, 4'b1111, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    step(17, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1);
    step(18, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1);
    step(19, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0);
    check("queue_empty", 32'(q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
